// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - double-buffered multi-digit 7-segment scan controller
// Optional leading-zero suppression: define SEG7_SCAN_LZ_BLANK_EN.
module seg7_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2,
  localparam int IDX_W = $clog2(NUM_DIGITS),
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  typedef enum logic {DEAD, SHOW} phase_t;

  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] active;
  logic                    dirty;
  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        cur_idx;
  phase_t                  phase;
  logic [NUM_DIGITS-1:0]   supp;

  // slot_cnt/cur_idx describe the cycle that the coming edge opens
  logic slot_end, last_slot, commit, show_now, dark;
  logic [4*NUM_DIGITS-1:0] commit_val;

  assign slot_end   = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
  assign last_slot  = (cur_idx == IDX_W'(NUM_DIGITS - 1));
  assign commit     = slot_end && last_slot;
  assign commit_val = load ? bcd_data : pending;
  assign show_now   = (phase == SHOW) || (DEAD_CYCLES == 0);
  assign dark       = blank_mask[cur_idx] || supp[cur_idx];

`ifdef SEG7_SCAN_LZ_BLANK_EN
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (v[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      supp <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    else if (commit && (load || dirty))
      supp <= lz_mask(commit_val);
  end
`else
  assign supp = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      active     <= '0;
      dirty      <= 1'b0;
      slot_cnt   <= '0;
      cur_idx    <= '0;
      phase      <= DEAD;
      bcd_out    <= 4'hF;
      digit_en   <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
      digit_idx  <= cur_idx;
      digit_en   <= show_now ? (NUM_DIGITS'(1) << cur_idx) : '0;
      if (slot_cnt == '0)
        bcd_out <= dark ? 4'hF : active[{cur_idx, 2'b00} +: 4];

      case (phase)
        DEAD: if (DEAD_CYCLES == 0 || slot_cnt == CNT_W'(DEAD_CYCLES - 1)) phase <= SHOW;
        SHOW: if (slot_end) phase <= (DEAD_CYCLES == 0) ? SHOW : DEAD;
        default: phase <= DEAD;
      endcase

      if (slot_end) begin
        slot_cnt <= '0;
        cur_idx  <= last_slot ? '0 : cur_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // A load landing on the commit edge bypasses pending straight into active
      if (load)
        pending <= bcd_data;
      if (commit && (load || dirty)) begin
        active <= commit_val;
        dirty  <= 1'b0;
      end else if (load) begin
        dirty <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexed scan controller for a multi-digit common-anode/cathode 7-segment display. It feeds one shared BCD-to-7-segment decoder with one digit at a time and enables the matching digit driver. It double-buffers the displayed value so a frame never tears, and inserts dead time between digits to suppress ghosting. It sits between the numeric datapath (counters, BCD converters) and the segment decoder plus digit-select pins.

## Interface
- NUM_DIGITS, 4: digits scanned; 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; at least 2.
- DEAD_CYCLES, 2: blanked cycles at the start of each slot; 0 ≤ DEAD_CYCLES < REFRESH_DIV.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  capture bcd_data into the pending buffer this cycle.
- bcd_data  in  4*NUM_DIGITS  digit i in bits [4i+3:4i]; digit 0 is least significant (rightmost).
- blank_mask  in  NUM_DIGITS  bit i=1 forces digit i dark; sampled live.
- bcd_out  out  4  code to the shared decoder; 4'hF means dark (the decoder default is all-off).
- digit_en  out  NUM_DIGITS  one-hot active-high digit select, or all-zero.
- digit_idx  out  clog2(NUM_DIGITS)  index of the current slot.
- frame_done  out  1  one-cycle pulse on the last cycle of a frame.

## Operation
- Registers:
  - pending buffer
  - active buffer
  - slot_cnt (0..REFRESH_DIV-1)
  - digit_idx (0..NUM_DIGITS-1)
  - phase FSM
- Reset values:
  - pending = 0, active = 0, slot_cnt = 0, digit_idx = 0, phase = DEAD
  - bcd_out = 4'hF, digit_en = 0, frame_done = 0
- Phase FSM:
  - DEAD: digit_en = 0. Go to SHOW when slot_cnt reaches DEAD_CYCLES-1. If DEAD_CYCLES = 0, DEAD is skipped and each slot enters SHOW directly.
  - SHOW: digit_en = one-hot(digit_idx). At slot_cnt = REFRESH_DIV-1:
    - slot_cnt goes to 0
    - digit_idx increments, wrapping NUM_DIGITS-1 → 0
    - phase goes to DEAD
- bcd_out:
  - Set at slot start from active[digit_idx].
  - Constant for the whole slot, including dead time.
  - Is 4'hF if blank_mask[digit_idx] = 1 or the digit is suppressed (see Configuration).
  - Digit codes above 9 pass through unchanged; the decoder renders them dark.
- Buffering:
  - load=1 writes bcd_data into pending and sets a dirty flag.
  - Frame commit is the edge where digit_idx wraps to 0. On that edge, if dirty, active ← pending and dirty clears.
  - load and commit in the same cycle: active ← bcd_data directly and dirty stays 0.
- frame_done: high exactly when digit_idx = NUM_DIGITS-1 and slot_cnt = REFRESH_DIV-1.
- Reset mid-slot: all outputs go to their reset values immediately (asynchronously). The scan restarts at digit 0 in DEAD, and pending data is lost.

## Timing
- Edge 0 is the first rising edge after rst deasserts. Slot k occupies cycles k*REFRESH_DIV .. (k+1)*REFRESH_DIV-1 after edge 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Load-to-display latency: data appears at the first commit after the load edge, worst case NUM_DIGITS*REFRESH_DIV cycles.
- blank_mask takes effect at the next slot start.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. Per digit, digit_en is high for REFRESH_DIV-DEAD_CYCLES cycles.
- digit_en never has more than one bit set. It is all-zero in every cycle where bcd_out changes.

## Configuration
- SEG7_SCAN_LZ_BLANK_EN, defined: leading-zero suppression.
  - Computed from active at commit and held for the frame.
  - Digit i is suppressed if every digit j ≥ i holds 0 and i ≠ 0; digit 0 is never suppressed.
  - Suppressed digits output bcd_out = 4'hF.
- Undefined: all digits shown as stored, no suppression logic synthesized.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
- Reset then free-run 64 cycles:
  - digit_en is 0 for cycles 0–1, 4'b0001 for cycles 2–7, 0 for cycles 8–9, 4'b0010 for cycles 10–15, and so on.
  - frame_done pulses at cycles 31 and 63.
  - bcd_out = 0 throughout.
- load bcd_data=16'h4321 at cycle 5:
  - bcd_out stays 0 until cycle 32.
  - Then slots show 1, 2, 3, 4.
- load 16'h1111 at cycle 10, then 16'h9876 at cycle 31 (the commit edge): the frame from cycle 32 shows 6, 7, 8, 9; 1111 is never displayed.
- blank_mask=4'b0100 with active=16'h4321: slot 2 shows bcd_out=4'hF; the other slots show 1, 2, 4.
- rst asserted at cycle 13 for 1 cycle: outputs are immediately at reset values; the scan restarts at digit 0 with DEAD for 2 cycles; active is 0.
- With SEG7_SCAN_LZ_BLANK_EN, load 16'h0050:
  - Slots show 0, 5, F, F.
  - Loading 16'h0000 then gives 0, F, F, F.
